// File: rtl/dp_tap_pkg.sv
// dp_tap_pkg: shared TAP state encoding, instruction codes and IR capture pattern.
package dp_tap_pkg;

    // Standard IEEE 1149.1 state encoding, so tap_state matches common debug tools
    typedef enum logic [3:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    // Instruction codes; BYPASS is all ones at whatever width the IR has
    localparam int INSTR_EXTEST = 0;
    localparam int INSTR_SAMPLE = 1;
    localparam int INSTR_IDCODE = 2;

    // Low bits loaded into the IR shift stage on CAPTURE_IR, zero-extended to IR width
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/dp_tap_sync.sv
// dp_tap_sync: brings the raw JTAG pins into the iclk domain and finds tck edges.
module dp_tap_sync (
    input  logic i_iclk,
    input  logic i_resetn,
    input  logic i_tck,
    input  logic i_tms,
    input  logic i_tdi,
    output logic o_tck_rise,
    output logic o_tck_fall,
    output logic o_tms,
    output logic o_tdi
);

    logic [2:0] r_tck_s;
    logic [1:0] r_tms_s;
    logic [1:0] r_tdi_s;

    // Two-flop synchronizers for all pins, plus a third tck flop for edge detection
    always_ff @(posedge i_iclk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_tck_s <= '0;
            r_tms_s <= '0;
            r_tdi_s <= '0;
        end else begin
            r_tck_s <= {r_tck_s[1:0], i_tck};
            r_tms_s <= {r_tms_s[0], i_tms};
            r_tdi_s <= {r_tdi_s[0], i_tdi};
        end
    end

    assign o_tck_rise = r_tck_s[1] & ~r_tck_s[2];
    assign o_tck_fall = ~r_tck_s[1] & r_tck_s[2];
    assign o_tms      = r_tms_s[1];
    assign o_tdi      = r_tdi_s[1];

endmodule

// File: rtl/dp_tap_ctrl.sv
// dp_tap_ctrl: oversampled JTAG TAP controller driving a boundary scan chain.
// Optional feature macro: DP_TAP_IDCODE_EN adds the IDCODE instruction and the
// 32-bit ID register, and makes IDCODE the reset instruction (BYPASS otherwise).
module dp_tap_ctrl
    import dp_tap_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic       iclk,
    input  logic       resetn,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_si,
    input  logic       bsr_so,
    output logic       bsr_mode,
    output logic       bsr_shift_dr,
    output logic       bsr_clk_dr,
    output logic       bsr_update_dr,
    output logic [3:0] tap_state
);

    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(IR_CAPTURE_LSBS);
    localparam logic [IR_W-1:0] IR_EXTEST  = IR_W'(INSTR_EXTEST);
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(INSTR_SAMPLE);
`ifdef DP_TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(INSTR_IDCODE);
    localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET   = '1;
`endif

    logic            w_tck_rise;
    logic            w_tck_fall;
    logic            w_tms;
    logic            w_tdi;
    tap_state_t      r_state;
    tap_state_t      w_next;
    logic [IR_W-1:0] r_ir_shift;
    logic [IR_W-1:0] r_ir;
    logic            r_bypass;
    logic            r_mode;
    logic            r_shift_dr;
    logic            r_clk_dr;
    logic            r_update_dr;
    logic            r_tdo;
    logic            r_tdo_en;
    logic            w_clk_dr_nxt;
    logic            w_update_dr_nxt;
    logic            w_sel_bsr;
    logic            w_sel_id;
    logic            w_id_lsb;
    logic            w_dr_lsb;

    dp_tap_sync u_sync (
        .i_iclk     (iclk),
        .i_resetn   (resetn),
        .i_tck      (tck),
        .i_tms      (tms),
        .i_tdi      (tdi),
        .o_tck_rise (w_tck_rise),
        .o_tck_fall (w_tck_fall),
        .o_tms      (w_tms),
        .o_tdi      (w_tdi)
    );

    assign w_sel_bsr = (r_ir == IR_EXTEST) || (r_ir == IR_SAMPLE);

`ifdef DP_TAP_IDCODE_EN
    logic [31:0] r_idreg;

    assign w_sel_id = (r_ir == IR_IDCODE);
    assign w_id_lsb = r_idreg[0];

    // ID register captures the fixed ID value and shifts tdi in from the top
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_idreg <= '0;
        end else if (w_tck_rise && w_sel_id) begin
            if (r_state == TAP_CAPTURE_DR) begin
                r_idreg <= IDCODE_VAL;
            end else if (r_state == TAP_SHIFT_DR) begin
                r_idreg <= {w_tdi, r_idreg[31:1]};
            end
        end
    end
`else
    // No ID register in this build; code 2 falls through to the bypass register
    assign w_sel_id = 1'b0;
    assign w_id_lsb = IDCODE_VAL[0];
`endif

    assign w_dr_lsb = w_sel_bsr ? bsr_so : (w_sel_id ? w_id_lsb : r_bypass);

    // State register advances once per synchronized tck rising edge
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= TAP_TEST_LOGIC_RESET;
        end else if (w_tck_rise) begin
            r_state <= w_next;
        end
    end

    // Standard 1149.1 transition table driven by synchronized tms
    always_comb begin
        w_next = r_state;
        case (r_state)
            TAP_TEST_LOGIC_RESET: w_next = w_tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    w_next = w_tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        w_next = w_tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       w_next = w_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         w_next = w_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         w_next = w_tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         w_next = w_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         w_next = w_tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        w_next = w_tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        w_next = w_tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       w_next = w_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         w_next = w_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         w_next = w_tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         w_next = w_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         w_next = w_tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        w_next = w_tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
            default:              w_next = TAP_TEST_LOGIC_RESET;
        endcase
    end

    // Chain strobes are decided from the state held before the tck_rise transition
    always_comb begin
        w_clk_dr_nxt    = 1'b0;
        w_update_dr_nxt = 1'b0;
        if (w_tck_rise && w_sel_bsr) begin
            w_clk_dr_nxt    = (r_state == TAP_CAPTURE_DR) || (r_state == TAP_SHIFT_DR);
            w_update_dr_nxt = (r_state == TAP_UPDATE_DR);
        end
    end

    // One-cycle strobes, with shift_dr moving on the same edge as its clk_dr pulse
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_clk_dr    <= 1'b0;
            r_update_dr <= 1'b0;
            r_shift_dr  <= 1'b0;
        end else begin
            r_clk_dr    <= w_clk_dr_nxt;
            r_update_dr <= w_update_dr_nxt;
            if (w_tck_rise) begin
                r_shift_dr <= (r_state == TAP_SHIFT_DR);
            end
        end
    end

    // Instruction register: capture/shift stage plus active IR, held at reset code in TLR
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_ir_shift <= '0;
            r_ir       <= IR_RESET;
        end else begin
            if (w_tck_rise) begin
                case (r_state)
                    TAP_CAPTURE_IR: r_ir_shift <= IR_CAPTURE;
                    TAP_SHIFT_IR:   r_ir_shift <= {w_tdi, r_ir_shift[IR_W-1:1]};
                    TAP_UPDATE_IR:  r_ir       <= r_ir_shift;
                    default:        ;
                endcase
            end
            if (r_state == TAP_TEST_LOGIC_RESET) begin
                r_ir <= IR_RESET;
            end
        end
    end

    // Bypass register captures 0 and delays tdi by one shift when selected
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_bypass <= 1'b0;
        end else if (w_tck_rise && !w_sel_bsr && !w_sel_id) begin
            if (r_state == TAP_CAPTURE_DR) begin
                r_bypass <= 1'b0;
            end else if (r_state == TAP_SHIFT_DR) begin
                r_bypass <= w_tdi;
            end
        end
    end

    // Registered cell mode so the pins switch cleanly after UPDATE_IR
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_mode <= 1'b0;
        end else begin
            r_mode <= (r_ir == IR_EXTEST);
        end
    end

    // tdo and its enable launch on the falling tck so the host samples on the next rise
    always_ff @(posedge iclk or negedge resetn) begin
        if (!resetn) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else if (w_tck_fall && !w_tck_rise) begin
            r_tdo_en <= (r_state == TAP_SHIFT_IR) || (r_state == TAP_SHIFT_DR);
            if (r_state == TAP_SHIFT_IR) begin
                r_tdo <= r_ir_shift[0];
            end else if (r_state == TAP_SHIFT_DR) begin
                r_tdo <= w_dr_lsb;
            end
        end
    end

    assign tdo           = r_tdo;
    assign tdo_en        = r_tdo_en;
    assign bsr_si        = w_tdi;
    assign bsr_mode      = r_mode;
    assign bsr_shift_dr  = r_shift_dr;
    assign bsr_clk_dr    = r_clk_dr;
    assign bsr_update_dr = r_update_dr;
    assign tap_state     = r_state;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// tb_dp_tap_ctrl: directed self-checking bench for dp_tap_ctrl.
// Exercises the DP_TAP_IDCODE_EN path when that macro is defined for the build.
module tb_dp_tap_ctrl;

    localparam logic [31:0] ID_VAL = 32'h1000_0001;

    logic       iclk = 1'b0;
    logic       resetn;
    logic       tck;
    logic       tms;
    logic       tdi;
    logic       bsr_so;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_si;
    logic       bsr_mode;
    logic       bsr_shift_dr;
    logic       bsr_clk_dr;
    logic       bsr_update_dr;
    logic [3:0] tap_state;

    int checks   = 0;
    int failures = 0;
    int clkCnt0  = 0;
    int clkCnt1  = 0;
    int updCnt   = 0;

    dp_tap_ctrl #(.IR_W(4), .IDCODE_VAL(ID_VAL)) dut (
        .iclk          (iclk),
        .resetn        (resetn),
        .tck           (tck),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_en        (tdo_en),
        .bsr_si        (bsr_si),
        .bsr_so        (bsr_so),
        .bsr_mode      (bsr_mode),
        .bsr_shift_dr  (bsr_shift_dr),
        .bsr_clk_dr    (bsr_clk_dr),
        .bsr_update_dr (bsr_update_dr),
        .tap_state     (tap_state)
    );

    // System clock, 10 ns period
    always #5 iclk = ~iclk;

    // Strobe monitor: counts high cycles, split by the shift_dr level seen with clk_dr
    always @(negedge iclk) begin
        if (bsr_clk_dr) begin
            if (bsr_shift_dr) clkCnt1 = clkCnt1 + 1;
            else              clkCnt0 = clkCnt0 + 1;
        end
        if (bsr_update_dr) updCnt = updCnt + 1;
    end

    // One slow tck period; tdo/tdo_en sampled late in the low phase
    task automatic tckCycle(input logic tmsV, input logic tdiV, output logic tdoV, output logic enV);
        tms = tmsV;
        tdi = tdiV;
        #10;
        tck = 1'b1;
        #50;
        tck = 1'b0;
        #49;
        tdoV = tdo;
        enV  = tdo_en;
        #1;
    endtask

    // From RUN_TEST_IDLE: load a 4-bit instruction, return the bits shifted out
    task automatic loadIr(input logic [3:0] val, output logic [3:0] outB, output int enCnt);
        logic d, e;
        enCnt = 0;
        outB  = '0;
        tckCycle(1'b1, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b1, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
        outB[0] = d;
        for (int i = 0; i < 4; i++) begin
            tckCycle(i == 3, val[i], d, e); enCnt += int'(e);
            if (i < 3) outB[i+1] = d;
        end
        tckCycle(1'b1, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
    endtask

    // From RUN_TEST_IDLE: n shift clocks through the selected DR, back to RUN_TEST_IDLE
    task automatic shiftDr(input int n, input logic [31:0] tdiB, output logic [31:0] outB, output int enCnt);
        logic d, e;
        enCnt = 0;
        outB  = '0;
        tckCycle(1'b1, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
        outB[0] = d;
        for (int i = 0; i < n; i++) begin
            tckCycle(i == n - 1, tdiB[i], d, e); enCnt += int'(e);
            if (i < n - 1) outB[i+1] = d;
        end
        tckCycle(1'b1, 1'b0, d, e); enCnt += int'(e);
        tckCycle(1'b0, 1'b0, d, e); enCnt += int'(e);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tck    = 1'b0;
        tms    = 1'b0;
        tdi    = 1'b0;
        bsr_so = 1'b0;
        #22;
        checks++; if (tap_state !== 4'hF) begin failures++; $display("[TB] FAIL reset_state: got %h expected F", tap_state); end
        checks++; if (tdo !== 1'b0) begin failures++; $display("[TB] FAIL reset_tdo: got %b expected 0", tdo); end
        checks++; if (tdo_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_tdo_en: got %b expected 0", tdo_en); end
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL reset_mode: got %b expected 0", bsr_mode); end
        checks++; if (bsr_shift_dr !== 1'b0) begin failures++; $display("[TB] FAIL reset_shift_dr: got %b expected 0", bsr_shift_dr); end
        checks++; if (bsr_clk_dr !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk_dr: got %b expected 0", bsr_clk_dr); end
        checks++; if (bsr_update_dr !== 1'b0) begin failures++; $display("[TB] FAIL reset_update_dr: got %b expected 0", bsr_update_dr); end
        checks++; if (bsr_si !== 1'b0) begin failures++; $display("[TB] FAIL reset_si: got %b expected 0", bsr_si); end
        resetn = 1'b1;
        #20;
    endtask

    task automatic test_tlr();
        logic d, e;
        tckCycle(1'b0, 1'b0, d, e);
        checks++; if (tap_state !== 4'hC) begin failures++; $display("[TB] FAIL tlr_to_idle: got %h expected C", tap_state); end
        tckCycle(1'b1, 1'b0, d, e);
        checks++; if (tap_state !== 4'h7) begin failures++; $display("[TB] FAIL idle_to_seldr: got %h expected 7", tap_state); end
        for (int i = 0; i < 5; i++) tckCycle(1'b1, 1'b0, d, e);
        checks++; if (tap_state !== 4'hF) begin failures++; $display("[TB] FAIL five_tms_tlr: got %h expected F", tap_state); end
        checks++; if (tdo_en !== 1'b0) begin failures++; $display("[TB] FAIL tlr_tdo_en: got %b expected 0", tdo_en); end
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL tlr_mode: got %b expected 0", bsr_mode); end
        tckCycle(1'b0, 1'b0, d, e);
    endtask

    task automatic test_extest();
        logic [3:0]  irOut;
        logic [31:0] drOut;
        int          en;
        int          c0, c1, u;
        loadIr(4'h0, irOut, en);
        checks++; if (irOut !== 4'b0001) begin failures++; $display("[TB] FAIL extest_ir_out: got %b expected 0001", irOut); end
        checks++; if (en !== 4) begin failures++; $display("[TB] FAIL extest_ir_en: got %0d expected 4", en); end
        checks++; if (bsr_mode !== 1'b1) begin failures++; $display("[TB] FAIL extest_mode: got %b expected 1", bsr_mode); end
        checks++; if (tap_state !== 4'hC) begin failures++; $display("[TB] FAIL extest_idle: got %h expected C", tap_state); end
        bsr_so = 1'b1;
        c0 = clkCnt0; c1 = clkCnt1; u = updCnt;
        shiftDr(8, 32'h0000_00A5, drOut, en);
        checks++; if (drOut !== 32'h0000_00FF) begin failures++; $display("[TB] FAIL extest_tdo_bsr: got %h expected 000000ff", drOut); end
        checks++; if (en !== 8) begin failures++; $display("[TB] FAIL extest_dr_en: got %0d expected 8", en); end
        checks++; if (clkCnt0 - c0 !== 1) begin failures++; $display("[TB] FAIL capture_pulses: got %0d expected 1", clkCnt0 - c0); end
        checks++; if (clkCnt1 - c1 !== 8) begin failures++; $display("[TB] FAIL shift_pulses: got %0d expected 8", clkCnt1 - c1); end
        checks++; if (updCnt - u !== 1) begin failures++; $display("[TB] FAIL update_pulses: got %0d expected 1", updCnt - u); end
        checks++; if (bsr_shift_dr !== 1'b0) begin failures++; $display("[TB] FAIL shift_dr_idle: got %b expected 0", bsr_shift_dr); end
        bsr_so = 1'b0;
    endtask

    task automatic test_bsr_si();
        tdi = 1'b1;
        #40;
        checks++; if (bsr_si !== 1'b1) begin failures++; $display("[TB] FAIL si_high: got %b expected 1", bsr_si); end
        tdi = 1'b0;
        #40;
        checks++; if (bsr_si !== 1'b0) begin failures++; $display("[TB] FAIL si_low: got %b expected 0", bsr_si); end
    endtask

    task automatic test_bypass();
        logic [3:0]  irOut;
        logic [31:0] drOut;
        int          en;
        int          c0, c1, u;
        loadIr(4'hF, irOut, en);
        checks++; if (irOut !== 4'b0001) begin failures++; $display("[TB] FAIL bypass_ir_out: got %b expected 0001", irOut); end
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL bypass_mode: got %b expected 0", bsr_mode); end
        c0 = clkCnt0; c1 = clkCnt1; u = updCnt;
        shiftDr(5, 32'h0000_000B, drOut, en);
        checks++; if (drOut !== 32'h0000_0016) begin failures++; $display("[TB] FAIL bypass_tdo: got %h expected 00000016", drOut); end
        checks++; if (en !== 5) begin failures++; $display("[TB] FAIL bypass_en: got %0d expected 5", en); end
        checks++; if ((clkCnt0 - c0) + (clkCnt1 - c1) !== 0) begin failures++; $display("[TB] FAIL bypass_clk_dr: got %0d expected 0", (clkCnt0 - c0) + (clkCnt1 - c1)); end
        checks++; if (updCnt - u !== 0) begin failures++; $display("[TB] FAIL bypass_update: got %0d expected 0", updCnt - u); end
    endtask

    task automatic test_undefined();
        logic [3:0]  irOut;
        logic [31:0] drOut;
        int          en;
        int          c0, c1;
        loadIr(4'h7, irOut, en);
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL undef_mode: got %b expected 0", bsr_mode); end
        c0 = clkCnt0; c1 = clkCnt1;
        shiftDr(3, 32'h0000_0005, drOut, en);
        checks++; if (drOut !== 32'h0000_0002) begin failures++; $display("[TB] FAIL undef_tdo: got %h expected 00000002", drOut); end
        checks++; if ((clkCnt0 - c0) + (clkCnt1 - c1) !== 0) begin failures++; $display("[TB] FAIL undef_clk_dr: got %0d expected 0", (clkCnt0 - c0) + (clkCnt1 - c1)); end
    endtask

`ifndef DP_TAP_IDCODE_EN
    task automatic test_code2_bypass();
        logic [3:0]  irOut;
        logic [31:0] drOut;
        int          en;
        loadIr(4'h2, irOut, en);
        shiftDr(4, 32'h0000_0007, drOut, en);
        checks++; if (drOut !== 32'h0000_000E) begin failures++; $display("[TB] FAIL code2_tdo: got %h expected 0000000e", drOut); end
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL code2_mode: got %b expected 0", bsr_mode); end
    endtask
`endif

    task automatic test_reset_mid_shift();
        logic [3:0] irOut;
        logic       d, e;
        logic       found;
        logic       sdBefore;
        int         en;
        int         u;
        loadIr(4'h0, irOut, en);
        tckCycle(1'b1, 1'b0, d, e);
        tckCycle(1'b0, 1'b0, d, e);
        tckCycle(1'b0, 1'b0, d, e);
        tckCycle(1'b0, 1'b1, d, e);
        checks++; if (tap_state !== 4'h2) begin failures++; $display("[TB] FAIL mid_in_shift: got %h expected 2", tap_state); end
        tms = 1'b0;
        tdi = 1'b0;
        #10;
        tck = 1'b1;
        found = 1'b0;
        sdBefore = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge iclk);
            if (bsr_clk_dr) begin
                found = 1'b1;
                sdBefore = bsr_shift_dr;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL mid_pulse_seen: got %b expected 1", found); end
        checks++; if (sdBefore !== 1'b1) begin failures++; $display("[TB] FAIL mid_shift_dr: got %b expected 1", sdBefore); end
        u = updCnt;
        resetn = 1'b0;
        #1;
        checks++; if (bsr_clk_dr !== 1'b0) begin failures++; $display("[TB] FAIL abort_clk_dr: got %b expected 0", bsr_clk_dr); end
        checks++; if (bsr_shift_dr !== 1'b0) begin failures++; $display("[TB] FAIL abort_shift_dr: got %b expected 0", bsr_shift_dr); end
        checks++; if (tap_state !== 4'hF) begin failures++; $display("[TB] FAIL abort_state: got %h expected F", tap_state); end
        checks++; if (bsr_mode !== 1'b0) begin failures++; $display("[TB] FAIL abort_mode: got %b expected 0", bsr_mode); end
        #1;
        tck = 1'b0;
        #50;
        resetn = 1'b1;
        #50;
        tckCycle(1'b1, 1'b0, d, e);
        tckCycle(1'b1, 1'b0, d, e);
        tckCycle(1'b0, 1'b0, d, e);
        checks++; if (updCnt - u !== 0) begin failures++; $display("[TB] FAIL abort_no_update: got %0d expected 0", updCnt - u); end
        checks++; if (tap_state !== 4'hC) begin failures++; $display("[TB] FAIL abort_idle: got %h expected C", tap_state); end
    endtask

`ifdef DP_TAP_IDCODE_EN
    task automatic test_idcode();
        logic [31:0] drOut;
        logic        d, e;
        int          en;
        resetn = 1'b0;
        #20;
        resetn = 1'b1;
        #20;
        tckCycle(1'b0, 1'b0, d, e);
        shiftDr(32, 32'h0, drOut, en);
        checks++; if (drOut !== ID_VAL) begin failures++; $display("[TB] FAIL idcode_stream: got %h expected %h", drOut, ID_VAL); end
        checks++; if (drOut[0] !== 1'b1) begin failures++; $display("[TB] FAIL idcode_first_bit: got %b expected 1", drOut[0]); end
        checks++; if (en !== 32) begin failures++; $display("[TB] FAIL idcode_en: got %0d expected 32", en); end
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_tlr();
        test_extest();
        test_bsr_si();
        test_bypass();
        test_undefined();
`ifndef DP_TAP_IDCODE_EN
        test_code2_bypass();
`endif
        test_reset_mid_shift();
`ifdef DP_TAP_IDCODE_EN
        test_idcode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog in case the sequence never completes
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dp_tap_ctrl.md
# dp_tap_ctrl

JTAG TAP controller that sequences a chain of debug boundary scan cells from the external JTAG pins. It oversamples raw `tck`/`tms`/`tdi` on the system clock, runs the IEEE 1149.1 16-state TAP FSM and an instruction register, and drives the chain's `mode`, `shift_dr`, `clk_dr` and `update_dr` controls as single-`iclk` strobes. It sits between the JTAG pads and the first and last boundary scan cells.

## Interface
- `IR_W`, 4, instruction register width (≥ 2)
- `IDCODE_VAL`, 32'h1000_0001, ID register value (LSB must be 1); used only with `DP_TAP_IDCODE_EN`
- `iclk  input  1`  system clock; all logic on `posedge iclk`
- `resetn  input  1`  asynchronous active-low reset
- `tck  input  1`  raw JTAG clock; asynchronous to `iclk`, f(iclk) ≥ 4·f(tck)
- `tms  input  1`  raw JTAG mode select
- `tdi  input  1`  raw JTAG data in
- `tdo  output  1`  JTAG data out
- `tdo_en  output  1`  tdo output enable; high only while shifting
- `bsr_si  output  1`  serial data to the first cell
- `bsr_so  input  1`  serial data from the last cell
- `bsr_mode  output  1`  cell mode; 1 selects the update latch onto the pins
- `bsr_shift_dr  output  1`  cell shift/capture select
- `bsr_clk_dr  output  1`  cell capture/shift enable strobe
- `bsr_update_dr  output  1`  cell update strobe
- `tap_state  output  4`  current TAP state encoding, for debug

## Operation
- Synchronizer: `tck`, `tms` and `tdi` each pass through 2 flops. A third `tck` flop feeds edge detect. `tck_rise = s2 & ~s3`, `tck_fall = ~s2 & s3`.
- FSM: 16 standard states. It advances only on `tck_rise`, using the synced `tms`. Five `tck_rise` with `tms=1` reach TEST_LOGIC_RESET from any state.
- Instructions: EXTEST = 0, SAMPLE = 1, IDCODE = 2, BYPASS = all ones. Undefined codes behave as BYPASS.
- IR:
  - CAPTURE_IR loads `{0…,01}`.
  - SHIFT_IR shifts right, with `tdi` into the MSB.
  - UPDATE_IR copies the shift stage to the active IR.
  - TEST_LOGIC_RESET forces the active IR to IDCODE if enabled, otherwise BYPASS.
- DR select: EXTEST and SAMPLE select the BSR chain, IDCODE selects the 32-bit ID register, everything else selects the 1-bit bypass register. CAPTURE_DR loads bypass = 0 and ID = `IDCODE_VAL`.
- On `tck_rise`, actions are taken for the state held *before* the transition:
  - `bsr_clk_dr` pulses for CAPTURE_DR or SHIFT_DR when BSR is selected.
  - `bsr_update_dr` pulses for UPDATE_DR when BSR is selected.
  - `bsr_shift_dr` is registered to (state == SHIFT_DR) and changes only on `tck_rise`, so it is stable during its own `bsr_clk_dr` pulse.
- `bsr_mode` = (active IR == EXTEST). It is registered.
- `bsr_si` = synced `tdi`.
- TDO: on `tck_fall`, `tdo` is set to the LSB of the selected register. The selected register is the IR shift stage in SHIFT_IR, or the DR in SHIFT_DR (`bsr_so` for BSR). On the same `tck_fall`, `tdo_en` is set to (state ∈ {SHIFT_IR, SHIFT_DR}).

## Timing
- Reset values:
  - state = TEST_LOGIC_RESET (`tap_state` = 4'hF).
  - `tdo` = 0, `tdo_en` = 0.
  - `bsr_mode` = `bsr_shift_dr` = `bsr_clk_dr` = `bsr_update_dr` = 0.
  - `bsr_si` = 0.
  - IR = reset instruction; all synchronizer flops = 0.
- Latency:
  - Pin `tck` rise to `tck_rise` asserted: 2–3 `iclk` edges.
  - `tck_rise` to state update and strobes: 1 edge.
- Strobes are exactly one `iclk` cycle wide, with at most one per `tck` period.
- `tck_rise` and `tck_fall` never coincide. If they did, `tck_rise` would take priority.
- Reset asserted mid-shift aborts the shift immediately:
  - no `bsr_update_dr` is issued;
  - strobes drop in the same cycle.
- Glitch-free `tck` is required; no filtering beyond the synchronizer.

## Configuration
- `DP_TAP_IDCODE_EN` defined:
  - IDCODE instruction and 32-bit ID register are present.
  - Reset instruction is IDCODE.
- Not defined:
  - No ID register; code 2 acts as BYPASS.
  - Reset instruction is BYPASS.

## Structure
- Package `dp_tap_pkg`:
  - TAP state enum (4-bit, standard 1149.1 encoding);
  - instruction code localparams;
  - IR capture pattern.
- Sub-module `dp_tap_sync`: 3-flop synchronizer plus edge detect for `tck`, and the 2-flop path for `tms`/`tdi`. Instantiated once.

## Test plan
- Reset, then 5 `tck` with `tms=1` → `tap_state` = 4'hF, `tdo_en` = 0, `bsr_mode` = 0.
- Load IR = 0 via SHIFT_IR → `tdo` shifts out `0001` LSB first, `bsr_mode` rises after UPDATE_IR. Then CAPTURE_DR, SHIFT_DR ×8 → 9 `bsr_clk_dr` pulses; first with `bsr_shift_dr` = 0, the rest with `bsr_shift_dr` = 1. One `bsr_update_dr` pulse follows.
- BYPASS, shift `tdi` pattern `1011` → `tdo` = `0`,`1`,`1`,`0`,`1` (one-bit delay); no `bsr_clk_dr` pulses.
- With `DP_TAP_IDCODE_EN`, after reset, shift DR for 32 clocks → `tdo` stream equals `IDCODE_VAL` LSB first, starting with 1.
- Assert `resetn` = 0 in SHIFT_DR mid-stream → all strobes are 0 the same cycle, state = TEST_LOGIC_RESET, no update pulse after release.
- Undefined IR = 4'h7 → behaves as BYPASS; `bsr_mode` = 0.
